// File: rtl/tour_cmd_sequencer.sv
// tour_cmd_sequencer
// Replays the knight's-tour solver's 24 one-hot moves as pairs of movement
// commands (vertical leg, then horizontal leg) to the command processor.
// Outside a tour, UART commands pass straight through to the same port.
//
// Handshake: a command is offered with cmd_rdy=1 and cmd stable. It is taken
// on the edge where clr_cmd_rdy=1. The sequencer then drops cmd_rdy and
// waits for send_resp, which marks the end of execution. send_resp is ignored
// while a command is offered, and clr_cmd_rdy is ignored while waiting.
module tour_cmd_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_active,
  output logic        tour_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VERT      = 3'd1,
    VERT_WAIT = 3'd2,
    HORZ      = 3'd3,
    HORZ_WAIT = 3'd4
  } state_t;

  localparam logic [4:0]  LAST_INDX   = 5'd23;
  localparam logic [3:0]  OP_MOVE     = 4'b0010;
  localparam logic [3:0]  OP_FANFARE  = 4'b0011;
  localparam logic [7:0]  HEAD_NORTH  = 8'h00;
  localparam logic [7:0]  HEAD_WEST   = 8'h3F;
  localparam logic [7:0]  HEAD_SOUTH  = 8'h7F;
  localparam logic [7:0]  HEAD_EAST   = 8'hBF;
  localparam logic [7:0]  RESP_FINAL  = 8'hA5;
  localparam logic [7:0]  RESP_INTER  = 8'h5A;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  mv_indx_nxt;

  logic        dx_pos;
  logic        dy_pos;
  logic [1:0]  dx_mag;
  logic [1:0]  dy_mag;
  logic        move_ok;
  logic        last_move;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;

  // Decode the one-hot move into signed leg lengths (sign flag + magnitude).
  always_comb begin
    dx_pos = 1'b0;
    dy_pos = 1'b0;
    dx_mag = 2'd0;
    dy_mag = 2'd0;
    unique case (move)
      8'h01: begin dx_pos = 1'b1; dx_mag = 2'd1; dy_pos = 1'b1; dy_mag = 2'd2; end
      8'h02: begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b1; dy_mag = 2'd2; end
      8'h04: begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
      8'h08: begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
      8'h10: begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
      8'h20: begin dx_pos = 1'b1; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
      8'h40: begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
      8'h80: begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
      default: begin end
    endcase
  end

  assign move_ok   = $onehot(move);
  assign last_move = (mv_indx == LAST_INDX);
  assign vert_cmd  = {OP_MOVE,    (dy_pos ? HEAD_NORTH : HEAD_SOUTH), 2'b00, dy_mag};
  assign horz_cmd  = {OP_FANFARE, (dx_pos ? HEAD_EAST  : HEAD_WEST),  2'b00, dx_mag};

  // State and move index registers; reset abandons any tour in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
    end else begin
      state   <= state_nxt;
      mv_indx <= mv_indx_nxt;
    end
  end

  // Next-state logic and command port muxing (UART passthrough in IDLE).
  always_comb begin
    state_nxt        = state;
    mv_indx_nxt      = mv_indx;
    cmd              = 16'h0000;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_INTER;
    tour_err         = 1'b0;
    unique case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_FINAL;
        if (start_tour) begin
          mv_indx_nxt = 5'd0;
          state_nxt   = VERT;
        end
      end
      VERT: begin
        if (!move_ok) begin
          tour_err  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cmd     = vert_cmd;
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) state_nxt = VERT_WAIT;
        end
      end
      VERT_WAIT: begin
        cmd = vert_cmd;
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = HORZ_WAIT;
      end
      HORZ_WAIT: begin
        cmd = horz_cmd;
        if (last_move) resp = RESP_FINAL;
        if (send_resp) begin
          if (last_move) begin
            state_nxt = IDLE;
          end else begin
            mv_indx_nxt = mv_indx + 5'd1;
            state_nxt   = VERT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tour_active = (state != IDLE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed testbench for tour_cmd_sequencer.
module tb_tour_cmd_sequencer;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_VERT      = 3'd1;
  localparam logic [2:0] S_VERT_WAIT = 3'd2;
  localparam logic [2:0] S_HORZ      = 3'd3;
  localparam logic [2:0] S_HORZ_WAIT = 3'd4;

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        tour_active;
  logic        tour_err;
  logic [2:0]  dbg_state;

  logic [7:0]  moves [24];
  int          checks;
  int          errors;
  int          acc_cnt;
  int          err_pulses;

  tour_cmd_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp),
    .tour_active      (tour_active),
    .tour_err         (tour_err),
    .dbg_state        (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Solver move memory, read combinationally by index
  assign move = (mv_indx < 5'd24) ? moves[mv_indx] : 8'h00;

  // Monitors: accepted tour commands and error pulses
  initial begin
    acc_cnt    = 0;
    err_pulses = 0;
  end
  always @(posedge clk) begin
    if (tour_active && cmd_rdy && clr_cmd_rdy) acc_cnt = acc_cnt + 1;
    if (tour_err) err_pulses = err_pulses + 1;
  end

  // Hand-computed leg commands for each move bit
  function automatic logic [15:0] vert_of(input logic [7:0] m);
    case (m)
      8'h01: vert_of = 16'h2002;
      8'h02: vert_of = 16'h2002;
      8'h04: vert_of = 16'h2001;
      8'h08: vert_of = 16'h27F1;
      8'h10: vert_of = 16'h27F2;
      8'h20: vert_of = 16'h27F2;
      8'h40: vert_of = 16'h27F1;
      8'h80: vert_of = 16'h2001;
      default: vert_of = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] horz_of(input logic [7:0] m);
    case (m)
      8'h01: horz_of = 16'h3BF1;
      8'h02: horz_of = 16'h33F1;
      8'h04: horz_of = 16'h33F2;
      8'h08: horz_of = 16'h33F2;
      8'h10: horz_of = 16'h33F1;
      8'h20: horz_of = 16'h3BF1;
      8'h40: horz_of = 16'h3BF2;
      8'h80: horz_of = 16'h3BF2;
      default: horz_of = 16'h0000;
    endcase
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Driver: one command leg from the offered state through send_resp
  task automatic leg(input string tag, input logic [15:0] exp_cmd,
                     input logic [7:0] exp_wait_resp, input int d1, input int d2);
    #1;
    chk({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
    chk({tag, "_rdy"}, 32'(cmd_rdy), 32'd1);
    chk({tag, "_resp_offer"}, 32'(resp), 32'h5A);
    repeat (d1) cyc();
    clr_cmd_rdy = 1'b1;
    #1;
    chk({tag, "_uart_clr"}, 32'(clr_cmd_rdy_UART), 32'd0);
    cyc();
    clr_cmd_rdy = 1'b0;
    #1;
    chk({tag, "_rdy_wait"}, 32'(cmd_rdy), 32'd0);
    chk({tag, "_resp_wait"}, 32'(resp), 32'(exp_wait_resp));
    repeat (d2) cyc();
    send_resp = 1'b1;
    cyc();
    send_resp = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    int base_acc;
    int base_err;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    cmd_UART     = 16'h2345;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    for (int i = 0; i < 24; i++) moves[i] = 8'h01 << ((i * 5) % 8);
    moves[0] = 8'h01;
    moves[1] = 8'h08;
    moves[2] = 8'h40;

    // Reset state and UART passthrough
    #3;
    chk("rst_cmd", 32'(cmd), 32'h2345);
    chk("rst_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_resp", 32'(resp), 32'hA5);
    chk("rst_active", 32'(tour_active), 32'd0);
    chk("rst_err", 32'(tour_err), 32'd0);
    chk("rst_indx", 32'(mv_indx), 32'd0);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("idle_uart_clr_hi", 32'(clr_cmd_rdy_UART), 32'd1);
    clr_cmd_rdy = 1'b0;
    #1;
    chk("idle_uart_clr_lo", 32'(clr_cmd_rdy_UART), 32'd0);
    #10 rst_n = 1'b1;
    cyc();
    cmd_rdy_UART = 1'b0;

    // Move 0: start, send_resp held in VERT, both strobes high in VERT
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
    #1;
    chk("m0v_cmd", 32'(cmd), 32'h2002);
    chk("m0v_rdy", 32'(cmd_rdy), 32'd1);
    chk("m0v_active", 32'(tour_active), 32'd1);
    send_resp = 1'b1;
    cyc();
    cyc();
    chk("hold_resp_state", 32'(dbg_state), 32'(S_VERT));
    chk("hold_resp_rdy", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    #1;
    chk("both_hi_state", 32'(dbg_state), 32'(S_VERT_WAIT));
    clr_cmd_rdy = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
    #1;
    chk("wait_clr_ignored", 32'(dbg_state), 32'(S_VERT_WAIT));
    send_resp = 1'b1;
    cyc();
    send_resp = 1'b0;
    leg("m0h", 16'h3BF1, 8'h5A, 0, 0);
    #1;
    chk("m1_indx", 32'(mv_indx), 32'd1);

    // Moves 1 and 2
    leg("m1v", 16'h27F1, 8'h5A, 1, 0);
    leg("m1h", 16'h33F2, 8'h5A, 0, 1);
    leg("m2v", 16'h27F1, 8'h5A, 0, 0);
    leg("m2h", 16'h3BF2, 8'h5A, 2, 2);
    #1;
    chk("m3_indx", 32'(mv_indx), 32'd3);

    // start_tour mid-tour is ignored
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
    #1;
    chk("mid_start_indx", 32'(mv_indx), 32'd3);
    chk("mid_start_state", 32'(dbg_state), 32'(S_VERT));

    // Reset during HORZ_WAIT
    leg("m3v", 16'h2001, 8'h5A, 0, 0);
    #1;
    chk("m3h_cmd", 32'(cmd), 32'h3BF2);
    clr_cmd_rdy = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
    #1;
    chk("m3h_wait_state", 32'(dbg_state), 32'(S_HORZ_WAIT));
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("async_rst_indx", 32'(mv_indx), 32'd0);
    chk("async_rst_active", 32'(tour_active), 32'd0);
    #3 rst_n = 1'b1;
    cyc();

    // Full 24-move replay with randomized responder delays
    base_acc   = acc_cnt;
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
    for (int i = 0; i < 24; i++) begin
      #1;
      chk($sformatf("full_indx_%0d", i), 32'(mv_indx), 32'(i));
      leg($sformatf("full_v%0d", i), vert_of(moves[i]), 8'h5A,
          $urandom_range(0, 5), $urandom_range(0, 5));
      leg($sformatf("full_h%0d", i), horz_of(moves[i]),
          (i == 23) ? 8'hA5 : 8'h5A, $urandom_range(0, 5), $urandom_range(0, 5));
    end
    #1;
    chk("full_end_state", 32'(dbg_state), 32'(S_IDLE));
    chk("full_end_active", 32'(tour_active), 32'd0);
    chk("full_end_indx", 32'(mv_indx), 32'd23);
    chk("full_end_resp", 32'(resp), 32'hA5);
    chk("full_acc_count", 32'(acc_cnt - base_acc), 32'd48);

    // Invalid move at index 5
    moves[5] = 8'h03;
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
    #1;
    chk("err_restart_indx", 32'(mv_indx), 32'd0);
    for (int i = 0; i < 5; i++) begin
      leg($sformatf("err_v%0d", i), vert_of(moves[i]), 8'h5A, 0, 0);
      leg($sformatf("err_h%0d", i), horz_of(moves[i]), 8'h5A, 0, 0);
    end
    base_acc = acc_cnt;
    base_err = err_pulses;
    #1;
    chk("err_pulse_hi", 32'(tour_err), 32'd1);
    chk("err_no_rdy", 32'(cmd_rdy), 32'd0);
    chk("err_indx", 32'(mv_indx), 32'd5);
    cyc();
    chk("err_state_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("err_pulse_lo", 32'(tour_err), 32'd0);
    chk("err_pulse_count", 32'(err_pulses - base_err), 32'd1);
    chk("err_no_accept", 32'(acc_cnt - base_acc), 32'd0);
    chk("err_idle_indx", 32'(mv_indx), 32'd5);
    cmd_UART     = 16'h1234;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("post_err_passthru_cmd", 32'(cmd), 32'h1234);
    chk("post_err_passthru_rdy", 32'(cmd_rdy), 32'd1);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
